ccff_bitstream_loader: RTL and testbench

// - Drives one configuration-chain segment (ccff_head -> ... -> ccff_tail) of a switch/connection-block

---
 rtl/ccff_loader_pkg.sv | 24 ++
 rtl/ccff_word_serdes.sv | 99 +++++++++
 rtl/ccff_bitstream_loader.sv | 109 ++++++++++
 tb/tb_ccff_bitstream_loader.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and elaboration-time helpers for the config-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Width of a counter that must hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int num_words(input int len, input int w);
    return (len + w - 1) / w;
  endfunction

  // Number of chain bits carried by the final (possibly partial) word.
  function automatic int last_bits(input int len, input int w);
    return len - (num_words(len, w) - 1) * w;
  endfunction

endpackage

// File: rtl/ccff_word_serdes.sv
// Word-wide PISO feeding ccff_head plus SIPO collecting ccff_tail into readback words.
module ccff_word_serdes
  import ccff_loader_pkg::*;
#(
  parameter  int WORD_W = 32,
  localparam int IDX_W  = cnt_w(WORD_W)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              clr,
  input  logic              ld,
  input  logic [WORD_W-1:0] ld_data,
  input  logic [IDX_W-1:0]  ld_bits,
  input  logic              shift,
  input  logic              shift_last,
  input  logic              ccff_tail,
  input  logic              m_ready,
  output logic              ccff_head,
  output logic              have_bit,
  output logic              last_bit,
  output logic              out_stall,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data
);

  logic [WORD_W-1:0] piso_q, piso_d;
  logic [WORD_W-1:0] sipo_q, sipo_d;
  logic [WORD_W-1:0] m_data_q, m_data_d;
  logic [WORD_W-1:0] cap_word;
  logic [IDX_W-1:0]  left_q, left_d;
  logic [IDX_W-1:0]  cap_q, cap_d;
  logic              m_valid_q, m_valid_d;

  always_comb begin
    piso_d    = piso_q;
    left_d    = left_q;
    sipo_d    = sipo_q;
    cap_d     = cap_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    cap_word  = sipo_q | (WORD_W'(ccff_tail) << cap_q);

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (shift) begin
      piso_d = piso_q >> 1;
      left_d = left_q - IDX_W'(1);
      sipo_d = cap_word;
      cap_d  = cap_q + IDX_W'(1);
      // A word closes when full or when the chain's last bit arrives (zero-filled above).
      if (cap_q == IDX_W'(WORD_W - 1) || shift_last) begin
        m_data_d  = cap_word;
        m_valid_d = 1'b1;
        sipo_d    = '0;
        cap_d     = '0;
      end
    end

    // A new word may land in the same cycle the old word's last bit leaves.
    if (ld) begin
      piso_d = ld_data;
      left_d = ld_bits;
    end

    if (clr) begin
      piso_d    = '0;
      left_d    = '0;
      sipo_d    = '0;
      cap_d     = '0;
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      piso_q    <= '0;
      left_q    <= '0;
      sipo_q    <= '0;
      cap_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      piso_q    <= piso_d;
      left_q    <= left_d;
      sipo_q    <= sipo_d;
      cap_q     <= cap_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign ccff_head = piso_q[0];
  assign have_bit  = (left_q != '0);
  assign last_bit  = (left_q == IDX_W'(1));
  assign out_stall = m_valid_q && !m_ready;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams host words into one config-chain segment and returns the displaced bits as readback.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W  = cnt_w(CHAIN_LEN);
  localparam int IDX_W  = cnt_w(WORD_W);
  localparam int NWORDS = num_words(CHAIN_LEN, WORD_W);
  localparam int WC_W   = cnt_w(NWORDS);

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  ALL_WORDS  = WC_W'(NWORDS);
  localparam logic [WC_W-1:0]  FINAL_WORD = WC_W'(NWORDS - 1);
  localparam logic [IDX_W-1:0] FULL_BITS  = IDX_W'(WORD_W);
  localparam logic [IDX_W-1:0] TAIL_BITS  = IDX_W'(last_bits(CHAIN_LEN, WORD_W));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]  words_q, words_d;

  logic             have_bit, last_bit, out_stall;
  logic             shift, shift_last, hs, clr;
  logic [IDX_W-1:0] ld_bits;

  always_comb begin
    shift      = (state_q == LOAD) && have_bit && !out_stall && !abort;
    shift_last = shift && (bit_cnt_q == LAST_CNT);
    s_ready    = (state_q == LOAD) && !abort && (words_q != ALL_WORDS) &&
                 (!have_bit || (last_bit && shift));
    hs         = s_valid && s_ready;
    ld_bits    = (words_q == FINAL_WORD) ? TAIL_BITS : FULL_BITS;
    done       = (state_q == FLUSH) && m_valid && m_ready && !abort;
    // Abort in IDLE must leave the outputs untouched, so only clear on a live abort.
    clr        = (abort && state_q != IDLE) || (state_q == IDLE && start && !abort);

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    if (shift) bit_cnt_d = bit_cnt_q + CNT_W'(1);
    if (hs)    words_d   = words_q + WC_W'(1);

    case (state_q)
      IDLE: if (start) begin
        state_d   = LOAD;
        bit_cnt_d = '0;
        words_d   = '0;
      end
      LOAD:    if (shift_last) state_d = FLUSH;
      FLUSH:   if (m_valid && m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      words_q   <= words_d;
    end
  end

  ccff_word_serdes #(.WORD_W(WORD_W)) u_serdes (
    .prog_clk   (prog_clk),
    .pReset     (pReset),
    .clr        (clr),
    .ld         (hs),
    .ld_data    (s_data),
    .ld_bits    (ld_bits),
    .shift      (shift),
    .shift_last (shift_last),
    .ccff_tail  (ccff_tail),
    .m_ready    (m_ready),
    .ccff_head  (ccff_head),
    .have_bit   (have_bit),
    .last_bit   (last_bit),
    .out_stall  (out_stall),
    .m_valid    (m_valid),
    .m_data     (m_data)
  );

  assign prog_clk_en = shift;
  assign busy        = (state_q == LOAD);

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench: two loaders (64-bit and 40-bit chains), each driving a behavioural shift-register chain.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0, s_valid = 1'b0, m_ready = 1'b1, sel = 1'b0;
  logic [31:0] s_data = '0;

  logic        a_s_ready, a_m_valid, a_head, a_tail, a_en, a_busy, a_done;
  logic [31:0] a_m_data;
  logic        b_s_ready, b_m_valid, b_head, b_tail, b_en, b_busy, b_done;
  logic [31:0] b_m_data;

  ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(64)) u_a (
    .prog_clk(clk), .pReset(rst), .start(start & ~sel), .abort(abort & ~sel),
    .s_valid(s_valid & ~sel), .s_ready(a_s_ready), .s_data(s_data),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data),
    .ccff_head(a_head), .ccff_tail(a_tail), .prog_clk_en(a_en), .busy(a_busy), .done(a_done));

  ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_b (
    .prog_clk(clk), .pReset(rst), .start(start & sel), .abort(abort & sel),
    .s_valid(s_valid & sel), .s_ready(b_s_ready), .s_data(s_data),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data),
    .ccff_head(b_head), .ccff_tail(b_tail), .prog_clk_en(b_en), .busy(b_busy), .done(b_done));

  // Chain models: head enters at the MSB, tail leaves from bit 0.
  logic [63:0] chain_a = '0;
  logic [39:0] chain_b = '0;
  always @(posedge clk) if (a_en) chain_a <= {a_head, chain_a[63:1]};
  always @(posedge clk) if (b_en) chain_b <= {b_head, chain_b[39:1]};
  assign a_tail = chain_a[0];
  assign b_tail = chain_b[0];

  wire        s_ready_m = sel ? b_s_ready : a_s_ready;
  wire        m_valid_m = sel ? b_m_valid : a_m_valid;
  wire [31:0] m_data_m  = sel ? b_m_data  : a_m_data;
  wire        en_m      = sel ? b_en      : a_en;
  wire        busy_m    = sel ? b_busy    : a_busy;
  wire        done_m    = sel ? b_done    : a_done;

  int          tests = 0, fails = 0;
  int          edges, enlow, dones, nrb;
  logic [31:0] rb [2];
  logic [63:0] snap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode: 0 plain, 1 s_valid gap, 2 m_ready gap, 3 extra start mid-load, 4 abort after 20 shifts
  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int mode);
    logic [31:0] w [2];
    int widx, sstall, mstall;
    bit strig, mtrig, atrig, finished;
    w[0] = w0; w[1] = w1;
    widx = 0; sstall = 0; mstall = 0;
    strig = 0; mtrig = 0; atrig = 0; finished = 0;
    edges = 0; enlow = 0; dones = 0; nrb = 0;
    rb[0] = 32'hBAD0BAD0; rb[1] = 32'hBAD1BAD1;
    @(negedge clk);
    s_valid = 1'b0; abort = 1'b0; m_ready = 1'b1; start = 1'b1;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      start = (mode == 3 && cyc == 10);
      abort = 1'b0;
      if (mode == 4 && !atrig && edges == 20) begin abort = 1'b1; atrig = 1; end
      if (mode == 2 && !mtrig && m_valid_m) begin mtrig = 1; mstall = 3; end
      m_ready = (mstall == 0);
      if (mstall > 0) mstall--;
      #1;
      if (mode == 1 && !strig && widx == 1 && s_ready_m) begin strig = 1; sstall = 5; end
      s_valid = (widx < 2) && (sstall == 0);
      s_data  = (widx < 2) ? w[widx] : 32'h0;
      if (sstall > 0) sstall--;
      #1;
      if (s_valid && s_ready_m) widx++;
      if (m_valid_m && m_ready) begin
        if (nrb < 2) rb[nrb] = m_data_m;
        nrb++;
      end
      if (en_m) edges++;
      if (busy_m && !en_m) enlow++;
      if (done_m) begin dones++; finished = 1; end
      if (mode == 4 && atrig && !abort) begin
        chk("abort_next_en", en_m, 0);
        chk("abort_next_busy", busy_m, 0);
        chk("abort_next_s_ready", s_ready_m, 0);
        chk("abort_next_m_valid", m_valid_m, 0);
        finished = 1;
      end
    end
    if (!finished) chk("load_timeout", 0, 1);
    s_valid = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
  endtask

  initial begin
    #12;
    chk("rst_s_ready", a_s_ready, 0);
    chk("rst_m_valid", a_m_valid, 0);
    chk("rst_m_data",  a_m_data, 0);
    chk("rst_head",    a_head, 0);
    chk("rst_en",      a_en, 0);
    chk("rst_busy",    a_busy, 0);
    chk("rst_done",    a_done, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", a_s_ready, 0);

    sel = 1'b0;
    run_load(32'hDEADBEEF, 32'h12345678, 0);
    chk("l1_chain", chain_a, 64'h12345678DEADBEEF);
    chk("l1_rb0", rb[0], 32'h0);
    chk("l1_rb1", rb[1], 32'h0);
    chk("l1_nrb", nrb, 2);
    chk("l1_edges", edges, 64);
    chk("l1_enlow", enlow, 1);
    chk("l1_dones", dones, 1);
    @(negedge clk);
    chk("l1_busy_after", a_busy, 0);
    chk("l1_done_once", a_done, 0);

    run_load(32'hFFFFFFFF, 32'h00000000, 3);
    chk("l2_rb0", rb[0], 32'hDEADBEEF);
    chk("l2_rb1", rb[1], 32'h12345678);
    chk("l2_edges", edges, 64);
    chk("l2_dones", dones, 1);
    chk("l2_chain", chain_a, 64'h00000000FFFFFFFF);

    run_load(32'hDEADBEEF, 32'h12345678, 1);
    chk("sgap_rb0", rb[0], 32'hFFFFFFFF);
    chk("sgap_rb1", rb[1], 32'h0);
    chk("sgap_enlow", enlow, 6);
    chk("sgap_edges", edges, 64);
    chk("sgap_chain", chain_a, 64'h12345678DEADBEEF);

    run_load(32'hCAFEF00D, 32'h0BADC0DE, 2);
    chk("mgap_rb0", rb[0], 32'hDEADBEEF);
    chk("mgap_rb1", rb[1], 32'h12345678);
    chk("mgap_enlow", enlow, 4);
    chk("mgap_edges", edges, 64);
    chk("mgap_chain", chain_a, 64'h0BADC0DECAFEF00D);

    run_load(32'h13579BDF, 32'h2468ACE0, 4);
    chk("abort_edges", edges, 20);
    chk("abort_dones", dones, 0);
    chk("abort_chain", chain_a, {20'h79BDF, 44'h0BADC0DECAF});

    snap = chain_a;
    run_load(32'h11111111, 32'h22222222, 0);
    chk("reload_rb0", rb[0], snap[31:0]);
    chk("reload_rb1", rb[1], snap[63:32]);
    chk("reload_dones", dones, 1);
    chk("reload_chain", chain_a, 64'h2222222211111111);

    // Asynchronous reset in the middle of a load.
    @(negedge clk); start = 1'b1; s_data = 32'hFFFFFFFF;
    @(negedge clk); start = 1'b0; s_valid = 1'b1;
    repeat (8) @(negedge clk);
    chk("prerst_busy", a_busy, 1);
    chk("prerst_head", a_head, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy",    a_busy, 0);
    chk("mid_rst_en",      a_en, 0);
    chk("mid_rst_head",    a_head, 0);
    chk("mid_rst_m_data",  a_m_data, 0);
    chk("mid_rst_m_valid", a_m_valid, 0);
    chk("mid_rst_s_ready", a_s_ready, 0);
    @(negedge clk); rst = 1'b0; s_valid = 1'b0;
    snap = chain_a;
    run_load(32'h55555555, 32'hAAAAAAAA, 0);
    chk("postrst_rb0", rb[0], snap[31:0]);
    chk("postrst_rb1", rb[1], snap[63:32]);
    chk("postrst_chain", chain_a, 64'hAAAAAAAA55555555);

    sel = 1'b1;
    run_load(32'hA5A5A5A5, 32'h000000C3, 0);
    chk("c40_chain", chain_b, 40'hC3A5A5A5A5);
    chk("c40_rb0", rb[0], 32'h0);
    chk("c40_rb1", rb[1], 32'h0);
    chk("c40_edges", edges, 40);
    chk("c40_dones", dones, 1);

    run_load(32'hFFFFFFFF, 32'hFFFFFF3C, 0);
    chk("c40b_rb0", rb[0], 32'hA5A5A5A5);
    chk("c40b_rb1", rb[1], 32'h000000C3);
    chk("c40b_edges", edges, 40);
    chk("c40b_chain", chain_b, 40'h3CFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
